tube_sched: RTL and testbench



---
 rtl/tube_sched.sv | 177 +++++++++++++++++
 tb/tb_tube_sched.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tube_sched.sv
// tube_sched -- issue scheduler for the shared exec-stage tubes (tube_0c, tube_4c, tube_8c).
//
// One op request per cycle, tagged with its hart and a one-hot tube select. A request is
// granted only when the target tube is free, the hart has no multi-cycle op in flight and
// the writeback slot the op would retire into is unclaimed, so at most one tube retires per
// cycle. Each retiring result is tagged with its originating hart.
//
// Optional feature: define TUBE_SCHED_CHECK_EN to compare i_tube_valid against the expected
// retire vector every cycle (sticky o_err_proto) and to assert i_req_tube is one-hot.
// Undefined: i_tube_valid is ignored and o_err_proto is tied low.
//
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_req_valid         op request
//   i_req_hart          requesting hart
//   i_req_tube          one-hot {8c,4c,0c} target
//   o_req_ready         request accepted when i_req_valid & o_req_ready
//   o_issue_sel         one-hot tube in_valid drive for the granted op
//   o_issue_hart        hart of the granted op
//   i_tube_valid        tube out_valid {8c,4c,0c} from exec (checked only with the macro)
//   o_done_valid        a tube result retires this cycle
//   o_done_tube         one-hot retiring tube
//   o_done_hart         hart owning the retiring result
//   o_hart_pending      per-hart multi-cycle op in flight
//   o_err_proto         sticky protocol error
module tube_sched #(
  parameter int unsigned HART_CNT = 4,
  parameter int unsigned HART_W   = $clog2(HART_CNT),
  parameter int unsigned LAT_4C   = 4,
  parameter int unsigned LAT_8C   = 8
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_req_valid,
  input  logic [HART_W-1:0]   i_req_hart,
  input  logic [2:0]          i_req_tube,
  output logic                o_req_ready,
  output logic [2:0]          o_issue_sel,
  output logic [HART_W-1:0]   o_issue_hart,
  input  logic [2:0]          i_tube_valid,
  output logic                o_done_valid,
  output logic [2:0]          o_done_tube,
  output logic [HART_W-1:0]   o_done_hart,
  output logic [HART_CNT-1:0] o_hart_pending,
  output logic                o_err_proto
);

  localparam int unsigned CNT_W = $clog2(LAT_8C);
  localparam logic [CNT_W-1:0] LOAD_4C = CNT_W'(LAT_4C - 1);
  localparam logic [CNT_W-1:0] LOAD_8C = CNT_W'(LAT_8C - 1);
  // Remaining count of an 8c op that would retire in the same cycle as a 4c op granted now.
  localparam logic [CNT_W-1:0] SLOT_4C = CNT_W'(LAT_4C);

  typedef enum logic {StIdle, StBusy} tube_st_e;

  tube_st_e            r_st4, r_st8, w_st4_nxt, w_st8_nxt;
  logic [CNT_W-1:0]    r_cnt4, r_cnt8, w_cnt4_nxt, w_cnt8_nxt;
  logic [HART_W-1:0]   r_tag4, r_tag8, w_tag4_nxt, w_tag8_nxt;
  logic [HART_CNT-1:0] r_pend, w_pend_nxt;
  logic                r_err, w_err_nxt;

  logic       w_done4, w_done8, w_blk0, w_blk4, w_blk8;
  logic       w_ready, w_grant, w_issue4, w_issue8;
  logic [2:0] w_done_vec;

  assign w_done4 = (r_st4 == StBusy) && (r_cnt4 == '0);
  assign w_done8 = (r_st8 == StBusy) && (r_cnt8 == '0);

  // Blocking terms per target tube. A busy tube in its done cycle may be re-granted.
  // An 8c target never collides with 4c: the 4c count never reaches LAT_8C.
  assign w_blk0 = w_done4 || w_done8;
  assign w_blk4 = ((r_st4 == StBusy) && (r_cnt4 != '0)) ||
                  ((r_st8 == StBusy) && (r_cnt8 == SLOT_4C));
  assign w_blk8 = (r_st8 == StBusy) && (r_cnt8 != '0);

  // Independent of i_req_valid so upstream may derive valid from ready.
  assign w_ready = !r_pend[i_req_hart] &&
                   !(i_req_tube[0] && w_blk0) &&
                   !(i_req_tube[1] && w_blk4) &&
                   !(i_req_tube[2] && w_blk8);
  assign w_grant  = i_req_valid && w_ready;
  assign w_issue4 = w_grant && i_req_tube[1];
  assign w_issue8 = w_grant && i_req_tube[2];

  assign w_done_vec = {w_done8, w_done4, w_grant && i_req_tube[0]};

  assign o_req_ready    = w_ready;
  assign o_issue_sel    = i_req_tube & {3{w_grant}};
  assign o_issue_hart   = i_req_hart;
  assign o_done_valid   = |w_done_vec;
  assign o_done_tube    = w_done_vec;
  assign o_hart_pending = r_pend;

  always_comb begin
    o_done_hart = '0;
    if (w_done8)            o_done_hart = r_tag8;
    else if (w_done4)       o_done_hart = r_tag4;
    else if (w_done_vec[0]) o_done_hart = i_req_hart;
  end

  always_comb begin
    w_st4_nxt  = r_st4;
    w_cnt4_nxt = r_cnt4;
    w_tag4_nxt = r_tag4;
    w_st8_nxt  = r_st8;
    w_cnt8_nxt = r_cnt8;
    w_tag8_nxt = r_tag8;
    w_pend_nxt = r_pend;
    w_err_nxt  = r_err;

    if (w_issue4) begin
      w_st4_nxt  = StBusy;
      w_cnt4_nxt = LOAD_4C;
      w_tag4_nxt = i_req_hart;
    end else if (r_st4 == StBusy) begin
      if (r_cnt4 == '0) w_st4_nxt = StIdle;
      else              w_cnt4_nxt = r_cnt4 - 1'b1;
    end

    if (w_issue8) begin
      w_st8_nxt  = StBusy;
      w_cnt8_nxt = LOAD_8C;
      w_tag8_nxt = i_req_hart;
    end else if (r_st8 == StBusy) begin
      if (r_cnt8 == '0) w_st8_nxt = StIdle;
      else              w_cnt8_nxt = r_cnt8 - 1'b1;
    end

    // Clear before set: the retiring hart is still pending, so it cannot be the new grantee.
    if (w_done4) w_pend_nxt[r_tag4] = 1'b0;
    if (w_done8) w_pend_nxt[r_tag8] = 1'b0;
    if (w_issue4 || w_issue8) w_pend_nxt[i_req_hart] = 1'b1;

`ifdef TUBE_SCHED_CHECK_EN
    if (i_tube_valid != w_done_vec) w_err_nxt = 1'b1;
`endif
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_st4  <= StIdle;
      r_cnt4 <= '0;
      r_tag4 <= '0;
      r_st8  <= StIdle;
      r_cnt8 <= '0;
      r_tag8 <= '0;
      r_pend <= '0;
      r_err  <= 1'b0;
    end else begin
      r_st4  <= w_st4_nxt;
      r_cnt4 <= w_cnt4_nxt;
      r_tag4 <= w_tag4_nxt;
      r_st8  <= w_st8_nxt;
      r_cnt8 <= w_cnt8_nxt;
      r_tag8 <= w_tag8_nxt;
      r_pend <= w_pend_nxt;
      r_err  <= w_err_nxt;
    end
  end

`ifdef TUBE_SCHED_CHECK_EN
  assign o_err_proto = r_err;
`ifndef SYNTHESIS
  always @(posedge i_clk) begin
    if (!i_rst && i_req_valid) begin
      assert ($onehot(i_req_tube))
        else $error("tube_sched: req_tube %b not one-hot", i_req_tube);
    end
  end
`endif
`else
  logic w_unused_tube_valid;
  assign w_unused_tube_valid = ^i_tube_valid;
  assign o_err_proto = r_err;
`endif

endmodule

// File: tb/tb_tube_sched.sv
// Self-checking bench for tube_sched: a per-cycle reference model of in-flight ops (absolute
// retire cycles per tube) plus directed sequences with hand-computed literal expectations.
module tb_tube_sched;

  localparam int HC = 4;
  localparam int L4 = 4;
  localparam int L8 = 8;
`ifdef TUBE_SCHED_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [1:0]  req_hart;
  logic [2:0]  req_tube;
  logic        req_ready;
  logic [2:0]  issue_sel;
  logic [1:0]  issue_hart;
  logic [2:0]  tube_valid;
  logic        done_valid;
  logic [2:0]  done_tube;
  logic [1:0]  done_hart;
  logic [3:0]  hart_pending;
  logic        err_proto;

  always #5 clk = ~clk;

  tube_sched #(.HART_CNT(HC), .LAT_4C(L4), .LAT_8C(L8)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_req_valid   (req_valid),
    .i_req_hart    (req_hart),
    .i_req_tube    (req_tube),
    .o_req_ready   (req_ready),
    .o_issue_sel   (issue_sel),
    .o_issue_hart  (issue_hart),
    .i_tube_valid  (tube_valid),
    .o_done_valid  (done_valid),
    .o_done_tube   (done_tube),
    .o_done_hart   (done_hart),
    .o_hart_pending(hart_pending),
    .o_err_proto   (err_proto)
  );

  // Model: latest op per multi-cycle tube with grant and retire cycle.
  int       cyc = 0;
  bit       v4 = 0, v8 = 0;
  int       g4, d4, g8, d8;
  logic [1:0] h4, h8;
  bit       m_err = 0;
  bit       frc = 0;
  logic [2:0] frc_val = 3'b000;

  int n_chk = 0;
  int n_fail = 0;

  function automatic bit m_pend(logic [1:0] h);
    return (v4 && h4 == h && cyc > g4 && cyc <= d4) || (v8 && h8 == h && cyc > g8 && cyc <= d8);
  endfunction

  function automatic bit m_ready(logic [1:0] h, logic [2:0] t);
    bit r;
    r = !m_pend(h);
    if (t[0] && ((v4 && d4 == cyc) || (v8 && d8 == cyc))) r = 0;
    if (t[1] && ((v4 && d4 > cyc) || (v8 && d8 == cyc + L4))) r = 0;
    if (t[2] && ((v8 && d8 > cyc) || (v4 && d4 == cyc + L8))) r = 0;
    return r;
  endfunction

  function automatic logic [2:0] m_done(bit v, logic [1:0] h, logic [2:0] t);
    return {v8 && d8 == cyc, v4 && d4 == cyc, v && t[0] && m_ready(h, t)};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d, t=%0t)", name, act, exp, cyc, $time);
    end
  endtask

  // Model state update at each active edge, using the inputs of the closing cycle.
  initial forever begin
    logic [2:0] e;
    @(posedge clk);
    if (rst) begin
      v4 = 0;
      v8 = 0;
      m_err = 0;
    end else begin
      e = m_done(req_valid, req_hart, req_tube);
      if (CHK && tube_valid !== e) m_err = 1;
      if (req_valid && m_ready(req_hart, req_tube)) begin
        if (req_tube[1]) begin v4 = 1; g4 = cyc; d4 = cyc + L4; h4 = req_hart; end
        if (req_tube[2]) begin v8 = 1; g8 = cyc; d8 = cyc + L8; h8 = req_hart; end
      end
    end
    cyc++;
  end

  // Per-cycle comparison against the model, mid-cycle.
  initial forever begin
    bit         g;
    logic [2:0] dv;
    logic [3:0] pv;
    @(negedge clk);
    if (!rst) begin
      g  = req_valid && m_ready(req_hart, req_tube);
      dv = m_done(req_valid, req_hart, req_tube);
      for (int h = 0; h < HC; h++) pv[h] = m_pend(2'(h));
      chk("m.req_ready", 32'(req_ready), 32'(m_ready(req_hart, req_tube)));
      chk("m.issue_sel", 32'(issue_sel), 32'(g ? req_tube : 3'b000));
      if (g) chk("m.issue_hart", 32'(issue_hart), 32'(req_hart));
      chk("m.done_valid", 32'(done_valid), 32'(|dv));
      chk("m.done_tube", 32'(done_tube), 32'(dv));
      if (|dv) chk("m.done_hart", 32'(done_hart),
                   32'(dv[2] ? h8 : (dv[1] ? h4 : req_hart)));
      chk("m.hart_pending", 32'(hart_pending), 32'(pv));
      chk("m.err_proto", 32'(err_proto), 32'(m_err));
    end
  end

  task automatic drive(bit v, logic [1:0] h, logic [2:0] t);
    @(posedge clk);
    #1;
    req_valid  = v;
    req_hart   = h;
    req_tube   = t;
    tube_valid = frc ? frc_val : m_done(v, h, t);
    @(negedge clk);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) drive(0, 2'd0, 3'b000);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1;
    req_valid = 0; req_hart = 0; req_tube = 0; tube_valid = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    @(negedge clk);
  endtask

  initial begin
    rst = 1;
    req_valid = 0; req_hart = 0; req_tube = 0; tube_valid = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    @(negedge clk);
    chk("rst.req_ready", 32'(req_ready), 32'd1);
    chk("rst.hart_pending", 32'(hart_pending), 32'd0);
    chk("rst.done_valid", 32'(done_valid), 32'd0);
    chk("rst.err_proto", 32'(err_proto), 32'd0);

    // 4c grant for hart 1, retires 4 cycles later.
    drive(1, 2'd1, 3'b010);
    chk("A.ready", 32'(req_ready), 32'd1);
    chk("A.issue_sel", 32'(issue_sel), 32'b010);
    for (int k = 1; k <= 5; k++) begin
      drive(0, 2'd0, 3'b000);
      chk("A.pending1", 32'(hart_pending[1]), 32'(k <= 4));
      chk("A.done_valid", 32'(done_valid), 32'(k == 4));
      if (k == 4) begin
        chk("A.done_tube", 32'(done_tube), 32'b010);
        chk("A.done_hart", 32'(done_hart), 32'd1);
      end
    end

    // 8c for hart 0 at 0; 4c for hart 2 at 4 would share slot 8.
    drive(1, 2'd0, 3'b100);
    chk("B.8c_ready", 32'(req_ready), 32'd1);
    idle(3);
    drive(1, 2'd2, 3'b010);
    chk("B.collide", 32'(req_ready), 32'd0);
    drive(1, 2'd2, 3'b010);
    chk("B.retry", 32'(req_ready), 32'd1);
    idle(2);
    drive(0, 2'd0, 3'b000);
    chk("B.done8_tube", 32'(done_tube), 32'b100);
    chk("B.done8_hart", 32'(done_hart), 32'd0);
    drive(0, 2'd0, 3'b000);
    chk("B.done4_tube", 32'(done_tube), 32'b010);
    chk("B.done4_hart", 32'(done_hart), 32'd2);
    idle(1);

    // 0c request in the 4c done cycle is held off, then retires in its grant cycle.
    drive(1, 2'd1, 3'b010);
    idle(3);
    drive(1, 2'd3, 3'b001);
    chk("C.blocked", 32'(req_ready), 32'd0);
    chk("C.done4_tube", 32'(done_tube), 32'b010);
    drive(1, 2'd3, 3'b001);
    chk("C.ready", 32'(req_ready), 32'd1);
    chk("C.issue_sel", 32'(issue_sel), 32'b001);
    chk("C.done_tube", 32'(done_tube), 32'b001);
    chk("C.done_hart", 32'(done_hart), 32'd3);
    drive(0, 2'd0, 3'b000);
    chk("C.no_pending", 32'(hart_pending), 32'd0);

    // Hart 1 is locked out of a second op until the cycle after its retire.
    drive(1, 2'd1, 3'b100);
    chk("D.first", 32'(req_ready), 32'd1);
    for (int k = 1; k <= 8; k++) begin
      drive(1, 2'd1, 3'b100);
      chk("D.locked", 32'(req_ready), 32'd0);
    end
    drive(1, 2'd1, 3'b100);
    chk("D.regrant", 32'(req_ready), 32'd1);
    chk("D.issue_sel", 32'(issue_sel), 32'b100);
    idle(10);

    // Re-grant of the 4c tube in its own done cycle.
    drive(1, 2'd0, 3'b010);
    idle(3);
    drive(1, 2'd1, 3'b010);
    chk("E.regrant", 32'(req_ready), 32'd1);
    chk("E.done_hart0", 32'(done_hart), 32'd0);
    idle(3);
    drive(0, 2'd0, 3'b000);
    chk("E.done_tube", 32'(done_tube), 32'b010);
    chk("E.done_hart1", 32'(done_hart), 32'd1);
    idle(2);

    // Early tube_valid two cycles after a 4c grant: sticky error only when checking is built in.
    drive(1, 2'd1, 3'b010);
    idle(1);
    frc = 1;
    frc_val = 3'b010;
    drive(0, 2'd0, 3'b000);
    frc = 0;
    for (int k = 3; k <= 7; k++) begin
      drive(0, 2'd0, 3'b000);
      chk("F.err_sticky", 32'(err_proto), 32'(CHK));
    end
    do_reset();
    chk("F.err_cleared", 32'(err_proto), 32'd0);
    chk("F.ready_after_rst", 32'(req_ready), 32'd1);

    // Random traffic, checked by the model every cycle.
    for (int i = 0; i < 400; i++) begin
      logic [2:0] t;
      t = 3'b001 << $urandom_range(0, 2);
      drive($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), t);
    end
    idle(12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
